// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: opcodes, reset PC, counter states.
package riscv_pkg;

    localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
    localparam logic [6:0]  OP_JAL       = 7'b1101111;
    localparam logic [6:0]  OP_JALR      = 7'b1100111;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // 2-bit saturating counter states; bit 1 is the taken/not-taken decision.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating branch counter.
module sat_counter2
    import riscv_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward taken or not-taken, sticking at either end.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch PC register plus a direct-mapped BTB with 2-bit counters and jump bits.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  CTR_INIT = WNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] correctpc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic        update_is_jump,
    output logic [31:0] fetch_pc,
    output logic [31:0] pred_nextpc,
    output logic        pred_taken
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic             jump_q   [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_alloc;
    logic             tbl_we;
    logic [1:0]       ctr_sat;
    logic [1:0]       ctr_wr;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];

    // Zero-latency lookup on the current fetch PC; sees pre-update table contents.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && (ctr_q[f_idx][1] || jump_q[f_idx]);
        pred_nextpc = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    end

    sat_counter2 u_sat (
        .ctr      (ctr_q[u_idx]),
        .taken    (update_taken),
        .ctr_next (ctr_sat)
    );

    // Decide whether the resolved instruction trains an entry and with what counter.
    always_comb begin
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_alloc = update_en && !u_hit && update_taken;
        tbl_we  = (update_en && u_hit) || u_alloc;
        if (update_is_jump) ctr_wr = ST;
        else if (u_hit)     ctr_wr = ctr_sat;
        else                ctr_wr = WT;
    end

    // Control state of the tables: cleared by reset, written on training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
                jump_q[i]  <= 1'b0;
            end
        end else if (tbl_we) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_wr;
            jump_q[u_idx]  <= update_is_jump;
        end
    end

    // Tag and target storage; gated by valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (u_alloc)
            tag_q[u_idx] <= u_tag;
        if (tbl_we && update_taken)
            target_q[u_idx] <= correctpc;
    end

    // Fetch PC: redirect beats stall, otherwise follow the prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      fetch_pc <= RESET_PC;
        else if (flush)  fetch_pc <= correctpc;
        else if (!stall) fetch_pc <= pred_nextpc;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised scoreboard bench for branch_predictor against a behavioural model.
module tb_branch_predictor;

    localparam int          IDX_W    = 6;
    localparam int          DEPTH    = 1 << IDX_W;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, update_en, update_taken, update_is_jump;
    logic [31:0] correctpc, update_pc;
    logic [31:0] fetch_pc, pred_nextpc;
    logic        pred_taken;

    branch_predictor #(.RESET_PC(RESET_PC), .IDX_W(IDX_W), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .correctpc(correctpc), .update_en(update_en), .update_pc(update_pc),
        .update_taken(update_taken), .update_is_jump(update_is_jump),
        .fetch_pc(fetch_pc), .pred_nextpc(pred_nextpc), .pred_taken(pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model: one record per table slot, addressed with plain arithmetic.
    bit          m_valid [DEPTH];
    bit [31:0]   m_tag   [DEPTH];
    bit [31:0]   m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    bit          m_jump  [DEPTH];
    bit [31:0]   m_pc;
    bit          m_rst;

    function automatic int slot(input bit [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit [31:0] tagof(input bit [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_jump[i] = 0;
            m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_pc  = RESET_PC;
        m_rst = 1;
    endtask

    task automatic m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] np);
        int i;
        i  = slot(pc);
        tk = m_hit(pc) && (m_ctr[i] >= 2 || m_jump[i]);
        np = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic m_train(input bit [31:0] upc, input bit tk, input bit jmp, input bit [31:0] cpc);
        int i;
        i = slot(upc);
        if (m_hit(upc)) begin
            if (jmp)     m_ctr[i] = 3;
            else if (tk) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else         m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            if (tk) m_tgt[i] = cpc;
            m_jump[i] = jmp;
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tagof(upc); m_tgt[i] = cpc;
            m_ctr[i] = jmp ? 3 : 2; m_jump[i] = jmp;
        end
    endtask

    // One clock: drive inputs, queue expected outputs for this cycle, advance the model.
    task automatic cycle(input bit st, input bit fl, input bit [31:0] cpc,
                         input bit ue, input bit [31:0] upc, input bit ut, input bit uj);
        bit        tk;
        bit [31:0] np, nxt;
        exp_t      e;
        stall = st; flush = fl; correctpc = cpc;
        update_en = ue; update_pc = upc; update_taken = ut; update_is_jump = uj;
        m_predict(m_pc, tk, np);
        e.pc = m_pc; e.npc = np; e.tk = tk;
        sb.push_back(e);
        if (m_rst)   nxt = m_pc;
        else if (fl) nxt = cpc;
        else if (st) nxt = m_pc;
        else         nxt = np;
        @(posedge clk);
        #1;
        if (!m_rst) begin
            if (ue) m_train(upc, ut, uj, cpc);
            m_pc = nxt;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic redirect(input bit [31:0] pc);
        cycle(0, 1, pc, 0, 32'h0, 0, 0);
    endtask

    task automatic train(input bit [31:0] upc, input bit tk, input bit jmp, input bit [31:0] cpc);
        cycle(0, 0, cpc, 1, upc, tk, jmp);
    endtask

    task automatic direct_check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear without a clock edge.
    task automatic async_reset();
        #5;
        rst_n = 1'b0;
        #1;
        direct_check("async_rst_fetch_pc", fetch_pc, RESET_PC);
        direct_check("async_rst_pred_nextpc", pred_nextpc, RESET_PC + 32'd4);
        direct_check("async_rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        m_rst = 0;
    endtask

    // Monitor: outputs are presented every cycle; compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (fetch_pc !== e.pc || pred_nextpc !== e.npc || pred_taken !== e.tk) begin
                errors++;
                $display("FAIL outputs t=%0t got pc=%h npc=%h tk=%b expected pc=%h npc=%h tk=%b",
                         $time, fetch_pc, pred_nextpc, pred_taken, e.pc, e.npc, e.tk);
            end
        end
    end

    function automatic bit [31:0] pool_pc();
        bit [31:0] t, i;
        t = $urandom_range(0, 2);
        i = $urandom_range(0, 7);
        return (t << (IDX_W + 2)) | (i << 2);
    endfunction

    initial begin
        stall = 0; flush = 0; correctpc = 0; update_en = 0;
        update_pc = 0; update_taken = 0; update_is_jump = 0;
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        m_rst = 0;

        // Sequential fetch from reset, then allocate 0x10 -> 0x40 and reach it.
        idle(3);
        train(32'h10, 1, 0, 32'h40);
        idle(3);
        // Weaken 0x10 to strongly not-taken, saturate, then one taken step.
        train(32'h10, 0, 0, 32'h14);
        train(32'h10, 0, 0, 32'h14);
        redirect(32'h10);
        idle(2);
        train(32'h10, 0, 0, 32'h14);
        train(32'h10, 1, 0, 32'h40);
        redirect(32'h10);
        idle(2);
        // Jump entry stays taken regardless of counter-lowering updates.
        train(32'h20, 1, 1, 32'h100);
        train(32'h20, 0, 1, 32'h24);
        train(32'h20, 0, 1, 32'h24);
        redirect(32'h20);
        idle(2);
        // Flush beats stall; stall alone holds.
        cycle(1, 1, 32'h200, 0, 32'h0, 0, 0);
        cycle(1, 0, 32'h0, 0, 32'h0, 0, 0);
        cycle(1, 0, 32'h0, 0, 32'h0, 0, 0);
        cycle(1, 0, 32'h0, 0, 32'h0, 0, 0);
        idle(1);
        // Aliasing: 0x110 replaces 0x10 in the same slot.
        train(32'h10, 1, 0, 32'h40);
        train(32'h110, 1, 0, 32'h80);
        redirect(32'h10);
        idle(1);
        redirect(32'h110);
        // Same-cycle update and lookup at one slot sees the old entry.
        train(32'h110, 1, 0, 32'h300);
        idle(1);
        redirect(32'h110);
        idle(1);
        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        idle(2);
        async_reset();
        idle(3);

        // Randomised traffic over a small PC pool so entries hit and alias.
        for (int n = 0; n < 2000; n++) begin
            bit st, fl, ue, ut, uj;
            bit [31:0] cpc, upc;
            st  = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 10);
            ue  = ($urandom_range(0, 99) < 45);
            uj  = ($urandom_range(0, 99) < 15);
            ut  = uj ? 1'b1 : bit'($urandom_range(0, 1));
            upc = pool_pc() | 32'($urandom_range(0, 3));
            cpc = pool_pc();
            cycle(st, fl, cpc, ue, upc, ut, uj);
            if (n == 1000) async_reset();
        end

        idle(1);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side next-PC generator and branch predictor. It owns the fetch PC register.
- Each cycle it predicts the next PC from a direct-mapped BTB with 2-bit saturating counters.
- It consumes the execute stage's resolution interface (update_en, branch taken, correct PC, flush) to redirect fetch and train the tables.
- pred_nextpc travels down the pipeline as the "nextpc" that execute compares against correctpc.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- IDX_W, 6, index width; table depth = 2**IDX_W entries.
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold fetch_pc (load-use stall from execute).
- flush  in  1  misprediction redirect from execute.
- correctpc  in  32  resolved next PC from execute; valid when flush or update_en.
- update_en  in  1  execute holds a resolved branch/JAL/JALR this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  branch taken (1 for JAL/JALR).
- update_is_jump  in  1  resolved instruction is JAL/JALR.
- fetch_pc  out  32  current fetch address.
- pred_nextpc  out  32  predicted address following fetch_pc.
- pred_taken  out  1  prediction for fetch_pc is taken.

Behaviour:
- Reset, asynchronous, active-low:
  - fetch_pc = RESET_PC.
  - All valid bits = 0; all counters = CTR_INIT; jump bits = 0.
  - Consequence: pred_nextpc = RESET_PC+4 and pred_taken = 0 combinationally. No reset values are required on tag/target arrays.
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup is combinational on fetch_pc, with zero latency:
  - hit = valid[idx] && tag[idx] == fetch tag.
  - pred_taken = hit && (ctr[idx][1] || jump[idx]).
  - pred_nextpc = pred_taken ? target[idx] : fetch_pc + 4.
  - PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
- fetch_pc register, priority order per rising edge:
  - If flush: fetch_pc <= correctpc.
  - Else if stall: hold.
  - Else: fetch_pc <= pred_nextpc.
  - flush overrides stall when both are asserted.
- Training occurs on the edge where update_en=1, independent of stall and flush:
  - Entry hit, i.e. tag match and valid at update_pc index:
    - Counter saturating: taken increments, capped at 2'b11; not-taken decrements, floored at 2'b00.
    - If taken, target <= correctpc.
    - jump <= update_is_jump.
  - Miss and taken allocates:
    - valid <= 1, tag <= update tag, target <= correctpc.
    - ctr <= 2'b10 (weakly taken), jump <= update_is_jump.
    - An existing entry at that index is replaced.
  - Miss and not taken: no table write.
  - Jump entries:
    - Counter is written 2'b11.
    - Prediction is always taken while the jump bit is set.
- Simultaneous update and lookup at the same index: lookup sees the pre-update contents. No bypass; the new state is visible the following cycle.
- Reset asserted mid-operation clears state immediately and asynchronously. The first edge after deassertion fetches from RESET_PC.
- No misprediction detection occurs here; flush comes solely from execute.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111.
  - RESET_PC default.
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
- One sub-module is natural: sat_counter2, the combinational next-state for a 2-bit counter given taken/not-taken.
- Tables are flop arrays in the top module.

Test Plan:
- Reset, then release with stall=0 and no updates -> fetch_pc sequence 0x0, 0x4, 0x8; pred_taken=0 throughout.
- update_en=1, update_pc=0x10, update_taken=1, correctpc=0x40, is_jump=0, then fetch reaches 0x10 -> pred_taken=1, pred_nextpc=0x40, and next fetch_pc=0x40.
- Same entry trained not-taken twice (ctr 10->01->00) -> at fetch 0x10, pred_taken=0, pred_nextpc=0x14; a third not-taken holds 00, then one taken gives 01, still not-taken.
- JAL at 0x20 to 0x100 (is_jump=1), then two not-taken updates at 0x20 -> pred_nextpc at 0x20 remains 0x100.
- flush=1 and stall=1 in the same cycle with correctpc=0x200 -> fetch_pc=0x200 next cycle; stall alone holds fetch_pc for 3 cycles.
- Aliasing: allocate 0x10 (target 0x40), then a taken update at 0x10+(4<<IDX_W)=0x110 to 0x80 -> lookup at 0x10 misses (0x14), lookup at 0x110 hits (0x80); update and lookup in the same cycle at one index return the old prediction.
